// File: rtl/register_file.sv
// RV32I integer register file: x0 hardwired to zero, two combinational datapath
// read ports with optional write-through forwarding, one write port, one debug read port.
module register_file #(
    parameter int                 XLEN     = 32,
    parameter logic [XLEN-1:0]    SP_RESET = XLEN'(32'h0000_1000),
    parameter bit                 BYPASS   = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    input  logic [4:0]      rd_addr,
    input  logic [XLEN-1:0] rd_data,
    input  logic            reg_write,
    input  logic [4:0]      dbg_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic [XLEN-1:0] dbg_data,
    output logic [15:0]     write_count
);

    logic [XLEN-1:0] regs_q [1:31];
    logic [15:0]     write_count_q;
    logic [15:0]     write_count_d;
    logic            wr_en;

    assign wr_en = reg_write && (rd_addr != 5'd0);

    function automatic logic [XLEN-1:0] stored(input logic [4:0] addr);
        if (addr == 5'd0) begin
            return '0;
        end
        return regs_q[addr];
    endfunction

    always_comb begin
        // NOTE: 16-bit add wraps 16'hFFFF to 0 naturally; no saturation logic wanted.
        write_count_d = write_count_q;
        if (wr_en) begin
            write_count_d = write_count_q + 16'd1;
        end
    end

    // NOTE: the storage array is reset on purpose so no register can ever read X;
    // x2 comes up as the stack pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < 32; i++) begin
                regs_q[i] <= (i == 2) ? SP_RESET : '0;
            end
            write_count_q <= '0;
        end else begin
            if (wr_en) begin
                regs_q[rd_addr] <= rd_data;
            end
            write_count_q <= write_count_d;
        end
    end

    // A match implies rd_addr != 0, so address 0 can never be forwarded.
    always_comb begin
        rs1_data = stored(rs1_addr);
        rs2_data = stored(rs2_addr);
        if (BYPASS && wr_en && (rs1_addr == rd_addr)) begin
            rs1_data = rd_data;
        end
        if (BYPASS && wr_en && (rs2_addr == rd_addr)) begin
            rs2_data = rd_data;
        end
    end

    assign dbg_data    = stored(dbg_addr);
    assign write_count = write_count_q;

endmodule

// File: tb/tb_register_file.sv
// Directed bench: one forwarding instance and one non-forwarding instance share stimulus.
module tb_register_file;

    localparam logic [31:0] SP_RST = 32'h0000_1000;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr, dbg_addr;
    logic [31:0] rd_data;
    logic        reg_write;
    logic [31:0] rs1_data, rs2_data, dbg_data;
    logic [31:0] nb_rs1_data, nb_rs2_data, nb_dbg_data;
    logic [15:0] write_count, nb_write_count;

    int checks = 0;
    int errors = 0;

    register_file #(.XLEN(32), .SP_RESET(SP_RST), .BYPASS(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rd_addr(rd_addr), .rd_data(rd_data), .reg_write(reg_write), .dbg_addr(dbg_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .dbg_data(dbg_data),
        .write_count(write_count)
    );

    register_file #(.XLEN(32), .SP_RESET(SP_RST), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rd_addr(rd_addr), .rd_data(rd_data), .reg_write(reg_write), .dbg_addr(dbg_addr),
        .rs1_data(nb_rs1_data), .rs2_data(nb_rs2_data), .dbg_data(nb_dbg_data),
        .write_count(nb_write_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        reg_write = 1'b0;
        rd_addr   = 5'd0;
        rd_data   = '0;
        rs1_addr  = 5'd0;
        rs2_addr  = 5'd0;
        dbg_addr  = 5'd0;

        // Reset held for two cycles, then sweep every register via the debug port.
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int a = 0; a < 32; a++) begin
            dbg_addr = 5'(a);
            #1;
            check($sformatf("reset_dbg_x%0d", a), dbg_data, (a == 2) ? SP_RST : 32'h0);
            check($sformatf("reset_nb_dbg_x%0d", a), nb_dbg_data, (a == 2) ? SP_RST : 32'h0);
        end
        check("reset_write_count", {16'h0, write_count}, 32'h0);

        // Basic write x7, read back next cycle.
        @(negedge clk);
        rst_n     = 1'b1;
        reg_write = 1'b1;
        rd_addr   = 5'd7;
        rd_data   = 32'hDEAD_BEEF;
        @(negedge clk);
        reg_write = 1'b0;
        rs1_addr  = 5'd7;
        rs2_addr  = 5'd0;
        #1;
        check("basic_rs1", rs1_data, 32'hDEAD_BEEF);
        check("basic_rs2", rs2_data, 32'h0);
        check("basic_nb_rs1", nb_rs1_data, 32'hDEAD_BEEF);
        check("basic_count", {16'h0, write_count}, 32'd1);

        // Write to x0 while reading x0 is discarded.
        @(negedge clk);
        reg_write = 1'b1;
        rd_addr   = 5'd0;
        rd_data   = 32'hFFFF_FFFF;
        rs1_addr  = 5'd0;
        rs2_addr  = 5'd0;
        #1;
        check("x0_bypass_rs1", rs1_data, 32'h0);
        check("x0_bypass_rs2", rs2_data, 32'h0);
        @(negedge clk);
        reg_write = 1'b0;
        dbg_addr  = 5'd0;
        #1;
        check("x0_dbg", dbg_data, 32'h0);
        check("x0_count", {16'h0, write_count}, 32'd1);

        // Same-cycle write x5 with both ports reading x5.
        @(negedge clk);
        reg_write = 1'b1;
        rd_addr   = 5'd5;
        rd_data   = 32'h0000_1234;
        rs1_addr  = 5'd5;
        rs2_addr  = 5'd5;
        dbg_addr  = 5'd5;
        #1;
        check("byp_rs1", rs1_data, 32'h0000_1234);
        check("byp_rs2", rs2_data, 32'h0000_1234);
        check("nobyp_rs1_old", nb_rs1_data, 32'h0);
        check("nobyp_rs2_old", nb_rs2_data, 32'h0);
        check("byp_dbg_not_fwd", dbg_data, 32'h0);
        @(negedge clk);
        reg_write = 1'b0;
        #1;
        check("nobyp_rs1_new", nb_rs1_data, 32'h0000_1234);
        check("nobyp_rs2_new", nb_rs2_data, 32'h0000_1234);
        check("byp_dbg_after", dbg_data, 32'h0000_1234);
        check("byp_count", {16'h0, write_count}, 32'd2);

        // Async reset lands mid-cycle while a write of x3 is pending.
        @(negedge clk);
        reg_write = 1'b1;
        rd_addr   = 5'd3;
        rd_data   = 32'h0000_00AA;
        @(negedge clk);
        dbg_addr  = 5'd3;
        rd_data   = 32'h0000_0055;
        #1;
        check("pre_rst_x3", dbg_data, 32'h0000_00AA);
        check("pre_rst_count", {16'h0, write_count}, 32'd3);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_x3", dbg_data, 32'h0);
        check("rst_mid_nb_x3", nb_dbg_data, 32'h0);
        check("rst_mid_count", {16'h0, write_count}, 32'h0);
        dbg_addr = 5'd2;
        #1;
        check("rst_mid_sp", dbg_data, SP_RST);
        @(negedge clk);
        reg_write = 1'b0;
        rst_n     = 1'b1;
        dbg_addr  = 5'd3;
        #1;
        check("rst_after_x3", dbg_data, 32'h0);
        dbg_addr = 5'd7;
        #1;
        check("rst_after_x7", dbg_data, 32'h0);

        // Counter wrap: 65535 writes reach 16'hFFFF, the next returns to 0.
        reg_write = 1'b1;
        rd_addr   = 5'd1;
        for (int i = 0; i < 65535; i++) begin
            rd_data = 32'hC000_0000 + 32'(i);
            @(negedge clk);
        end
        #1;
        check("wrap_count_max", {16'h0, write_count}, 32'h0000_FFFF);
        rd_data = 32'hC000_FFFF;
        @(negedge clk);
        reg_write = 1'b0;
        dbg_addr  = 5'd1;
        #1;
        check("wrap_count_zero", {16'h0, write_count}, 32'h0);
        check("wrap_nb_count_zero", {16'h0, nb_write_count}, 32'h0);
        check("wrap_x1_last", dbg_data, 32'hC000_FFFF);
        dbg_addr = 5'd2;
        #1;
        check("wrap_sp_kept", dbg_data, SP_RST);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
